addsub_accumulator: RTL and testbench



---
 rtl/addsub_accumulator.sv | 104 ++++++++++
 tb/tb_addsub_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accumulator.sv
// rtl/addsub_accumulator.sv - signed 4-bit add/subtract accumulator with valid/ready operand and result streams
// A ripple add/sub datapath folds each accepted beat into acc; the final value is offered once the last beat is taken.
module addsub_accumulator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_sub,
  input  logic       in_last,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_sum,
  output logic       res_carry,
  output logic       res_ovf,
  output logic [3:0] res_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic [3:0] count_q, count_d;

  logic [3:0] b_inv;
  logic [3:0] sum;
  logic [4:0] c;
  logic       accept;

  // Ripple chain: c[i] is the carry into bit i, c[0] doubles as the subtract carry-in.
  always_comb begin
    b_inv = in_data ^ {4{in_sub}};
    c     = 5'd0;
    sum   = 4'd0;
    c[0]  = in_sub;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = acc_q[i] ^ b_inv[i] ^ c[i];
      c[i+1]   = (acc_q[i] & b_inv[i]) | (c[i] & (acc_q[i] ^ b_inv[i]));
    end
  end

  assign accept = in_valid && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = 4'd0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          count_d = 4'd0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_d   = sum;
          carry_d = c[4];
          ovf_d   = ovf_q | (c[4] ^ c[3]);
          count_d = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == RUN);
  assign res_valid = (state_q == DONE);
  assign res_sum   = acc_q;
  assign res_carry = carry_q;
  assign res_ovf   = ovf_q;
  assign res_count = count_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// tb/tb_addsub_accumulator.sv - directed self-checking bench for addsub_accumulator
module tb_addsub_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sub;
  logic       in_last;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_sum;
  logic       res_carry;
  logic       res_ovf;
  logic [3:0] res_count;

  int total = 0;
  int bad   = 0;

  addsub_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [3:0] d, input logic s, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
    in_sub   = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_idle busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      in_sub    = 1'($urandom_range(0, 1));
      in_last   = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
      step();
      outs = {busy, in_ready, res_valid, res_sum, res_carry, res_ovf, res_count};
      total++;
      if (outs !== 13'd0) begin
        bad++;
        $display("FAIL reset_outputs got=%h want 0", outs);
      end
    end
    start = 0; in_valid = 0; in_data = 0; in_sub = 0; in_last = 0; res_ready = 0;
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 4'd3;
    in_last  = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
    total++;
    if ({busy, in_ready, res_valid, res_count} !== 7'd0) begin
      bad++;
      $display("FAIL idle_no_accept busy=%0b rdy=%0b rv=%0b cnt=%0d want all 0", busy, in_ready, res_valid, res_count);
    end
  endtask

  task automatic test_add();
    do_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_start busy=%0b rdy=%0b want 1 1", busy, in_ready);
    end
    beat(4'd3, 1'b0, 1'b0);
    total++;
    if (res_sum !== 4'd3 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_first sum=%0d rv=%0b want 3 0", res_sum, res_valid);
    end
    beat(4'd4, 1'b0, 1'b1);
    total++;
    if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL add_latency rv=%0b rdy=%0b want 1 0", res_valid, in_ready);
    end
    total++;
    if ({res_sum, res_carry, res_ovf, res_count} !== {4'd7, 1'b0, 1'b0, 4'd2}) begin
      bad++;
      $display("FAIL add_result sum=%0d c=%0b v=%0b cnt=%0d want 7 0 0 2", res_sum, res_carry, res_ovf, res_count);
    end
    drain();
  endtask

  task automatic test_overflow();
    do_start();
    beat(4'd5, 1'b0, 1'b0);
    beat(4'd4, 1'b0, 1'b1);
    total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_count} !== {1'b1, 4'b1001, 1'b0, 1'b1, 4'd2}) begin
      bad++;
      $display("FAIL ovf_result rv=%0b sum=%b c=%0b v=%0b cnt=%0d want 1 1001 0 1 2", res_valid, res_sum, res_carry, res_ovf, res_count);
    end
    drain();
  endtask

  task automatic test_subtract();
    do_start();
    beat(4'd2, 1'b0, 1'b0);
    beat(4'd3, 1'b1, 1'b1);
    total++;
    if ({res_valid, res_sum, res_carry, res_ovf} !== {1'b1, 4'hF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_borrow rv=%0b sum=%h c=%0b v=%0b want 1 f 0 0", res_valid, res_sum, res_carry, res_ovf);
    end
    drain();
    do_start();
    beat(4'd5, 1'b0, 1'b0);
    beat(4'd2, 1'b1, 1'b1);
    total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_count} !== {1'b1, 4'd3, 1'b1, 1'b0, 4'd2}) begin
      bad++;
      $display("FAIL sub_noborrow rv=%0b sum=%0d c=%0b v=%0b cnt=%0d want 1 3 1 0 2", res_valid, res_sum, res_carry, res_ovf, res_count);
    end
    drain();
  endtask

  task automatic test_wrap_saturate();
    int n = 0;
    int cyc = 0;
    do_start();
    in_data = 4'd1;
    in_sub  = 1'b0;
    while (n < 17 && cyc < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = (n == 16);
      if (in_valid && in_ready) n++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'd0;
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL wrap_timeout beats=%0d want 17", n);
    end
    total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_count} !== {1'b1, 4'd1, 1'b0, 1'b1, 4'd15}) begin
      bad++;
      $display("FAIL wrap_result rv=%0b sum=%0d c=%0b v=%0b cnt=%0d want 1 1 0 1 15", res_valid, res_sum, res_carry, res_ovf, res_count);
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_start();
    beat(4'd6, 1'b0, 1'b0);
    beat(4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      step();
      total++;
      if ({res_valid, busy, in_ready, res_sum, res_carry, res_ovf, res_count} !==
          {1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 4'd2}) begin
        bad++;
        $display("FAIL hold_%0d rv=%0b busy=%0b rdy=%0b sum=%0d c=%0b v=%0b cnt=%0d want 1 1 0 5 1 0 2",
                 i, res_valid, busy, in_ready, res_sum, res_carry, res_ovf, res_count);
      end
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL release rv=%0b busy=%0b want 0 0", res_valid, busy);
    end
  endtask

  task automatic test_midrun_reset();
    do_start();
    beat(4'd5, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, in_ready, res_valid, res_sum, res_carry, res_ovf, res_count} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset busy=%0b rdy=%0b sum=%0d cnt=%0d want all 0", busy, in_ready, res_sum, res_count);
    end
    step();
    rst_n = 1'b1;
    step();
    do_start();
    beat(4'd2, 1'b0, 1'b1);
    total++;
    if ({res_valid, res_sum, res_carry, res_ovf, res_count} !== {1'b1, 4'd2, 1'b0, 1'b0, 4'd1}) begin
      bad++;
      $display("FAIL after_reset rv=%0b sum=%0d c=%0b v=%0b cnt=%0d want 1 2 0 0 1", res_valid, res_sum, res_carry, res_ovf, res_count);
    end
    drain();
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_data = 0; in_sub = 0; in_last = 0; res_ready = 0;
    test_reset();
    test_add();
    test_overflow();
    test_subtract();
    test_wrap_saturate();
    test_backpressure();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
